subbytes_engine: RTL and testbench
==================================

# subbytes_engine

Parametrised, sequential AES SubBytes/InvSubBytes engine for the encryption/decryption datapath behind the PicoRV32 AXI4-Lite accelerator. It accepts one 128-bit state over a valid/ready handshake and substitutes `LANES` bytes per cycle using shared composite-field S-box lanes. It returns the result over a second valid/ready handshake. It trades area for latency compared with the fully parallel 16-S-box SubBytes stage, and adds a run-time inverse mode.

## Interface
- `LANES`, default 4: S-box lanes instantiated and bytes processed per cycle.
  - Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- `INV_EN`, default 1: 1 builds the inverse S-box path, selected per block by `in_inv`. 0 builds the forward path only, and `in_inv` is ignored.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `in_valid`  input  1  input block present.
- `in_ready`  output  1  engine can accept a block.
- `in_data`  input  128  state; byte k = bits [8k+7:8k].
- `in_inv`  input  1  1 = InvSubBytes, 0 = SubBytes; sampled with `in_data`.
- `out_valid`  output  1  result held on `out_data`.
- `out_ready`  input  1  consumer accepts result.
- `out_data`  output  128  substituted state; same byte ordering as `in_data`.
- `busy`  output  1  high in RUN or DONE.

## Operation
- `N = 16/LANES` passes. The pass counter `cnt` is `max(1,$clog2(N))` bits wide.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid&in_ready`: latch `in_data` into the state register, latch the mode (`in_inv & INV_EN`), clear `cnt`, go to RUN.
- **RUN**, one pass per cycle:
  - Bytes `cnt*LANES` to `cnt*LANES+LANES-1` pass through the lanes and are written back in place.
  - Other bytes hold.
  - When `cnt==N-1`, go to DONE; otherwise `cnt+1`.
  - With `LANES=16`, RUN lasts exactly one cycle.
- **DONE**
  - `out_valid=1`. `out_data` is the state register, stable until accepted.
  - On `out_valid&out_ready`:
    - If `in_valid` is also high in the same cycle, load the new block and go directly to RUN (back-to-back).
    - Otherwise go to IDLE.
- `in_ready = (state==IDLE) | (state==DONE & out_ready)`.
- Inputs are ignored in RUN; `in_ready=0` there.
- **Lane function**
  - Forward: GF(2^8) inverse computed in GF((2^4)^2) (isomorphic mapping, GF(2^4) multiply/square/inverse, inverse mapping), then the AES affine transform with constant 0x63.
  - Inverse: inverse affine transform (constant 0x05) first, then the same field inversion.
  - Both must match the FIPS-197 tables for all 256 inputs.
- **Reset**
  - On reset: state=IDLE, `cnt=0`, state register=0, mode=0.
  - Outputs under reset: `out_valid=0`, `out_data=0`, `busy=0`, `in_ready=1`.
  - Asserting `rst` in RUN or DONE aborts the block. No `out_valid` follows for it.

## Timing
- Block accepted at edge T produces `out_valid=1` in the cycle after edge T+N.
  - LANES=4: 4 cycles after acceptance.
  - LANES=1: 16 cycles.
  - LANES=16: 1 cycle.
- Sustained throughput is one block per N+1 cycles with `out_ready` held high.
- Back-to-back accept in DONE costs no IDLE cycle.
- All outputs are registered or decoded from state only, except `in_ready`, which depends combinationally on `out_ready`.
- There is no combinational path from `in_data` to `out_data`.
- The S-box lane is purely combinational between the state register and its write-back. The timing budget is one lane (about 30 XOR levels) per cycle.

## Test plan
- Reset, then `in_data=0`, `in_inv=0` -> after N cycles `out_data=128'h63636363636363636363636363636363`, `out_valid=1`, `busy=1`.
  - Holding `out_ready=0` for 5 cycles -> `out_data` stable; accept -> IDLE.
- `in_data=128'h0f0e0d0c0b0a09080706050403020100`, forward, for each of LANES in {1,4,16} -> `out_data=128'h76abd7fe2b670130c56f6bf27b777c63`, latency exactly N cycles.
- Inverse: feed `128'h76abd7fe2b670130c56f6bf27b777c63` with `in_inv=1`, INV_EN=1 -> `out_data=128'h0f0e0d0c0b0a09080706050403020100`.
  - Same stimulus with INV_EN=0 -> forward result.
- Exhaustive per-lane check: 16 blocks covering bytes 0x00–0xFF in both modes, compared against the FIPS-197 S-box/inverse table (e.g. 0x53->0xED, 0xFF->0x16, inverse 0x63->0x00).
- Back-to-back: `in_valid` held high, `out_ready` high -> new block accepted in the same cycle each result retires; period N+1 cycles; no block dropped or duplicated.
- Reset pulse asserted mid-RUN (`cnt=1`, LANES=4) -> `out_valid=0`, `busy=0`, `out_data=0` immediately; next block processes correctly.

Source files
------------

// File: rtl/subbytes_engine.sv
// subbytes_engine: sequential AES SubBytes/InvSubBytes over LANES shared composite-field S-box lanes.
// The GF(2^8) <-> GF((2^4)^2) basis change is derived at elaboration from a root of the AES polynomial.
module subbytes_engine #(
    parameter int LANES = 4,
    parameter bit INV_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int N = 16 / LANES;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam logic [3:0] LAMBDA = 4'hc;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    // GF(2^4) modulo x^4+x+1
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf16_sq(input logic [3:0] a);
        return gf16_mul(a, a);
    endfunction

    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf16_sq(a);
        a4 = gf16_sq(a2);
        a8 = gf16_sq(a4);
        return gf16_mul(gf16_mul(a8, a4), a2);
    endfunction

    // GF((2^4)^2) modulo y^2+y+LAMBDA, byte = {high, low}
    function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        hh = gf16_mul(a[7:4], b[7:4]);
        return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
                gf16_mul(hh, LAMBDA) ^ gf16_mul(a[3:0], b[3:0])};
    endfunction

    function automatic logic [7:0] gf256_inv(input logic [7:0] a);
        logic [3:0] d;
        d = gf16_inv(gf16_mul(gf16_sq(a[7:4]), LAMBDA) ^ gf16_mul(a[7:4], a[3:0]) ^ gf16_sq(a[3:0]));
        return {gf16_mul(a[7:4], d), gf16_mul(a[7:4] ^ a[3:0], d)};
    endfunction

    function automatic logic [7:0] map(input logic [63:0] m, input logic [7:0] a);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = a[i] ? r ^ m[8*i +: 8] : r;
        return r;
    endfunction

    // Powers beta^0..beta^7 of the first composite-field root of x^8+x^4+x^3+x+1
    function automatic logic [63:0] iso_basis();
        logic [71:0] pw;
        logic [63:0] m;
        m = '0;
        for (int c = 2; c < 256; c++) begin
            pw = '0;
            pw[7:0] = 8'h01;
            for (int i = 1; i < 9; i++) pw[8*i +: 8] = gf256_mul(pw[8*(i-1) +: 8], 8'(c));
            if (m == '0 && (pw[71:64] ^ pw[39:32] ^ pw[31:24] ^ pw[15:8] ^ pw[7:0]) == 8'h00)
                m = pw[63:0];
        end
        return m;
    endfunction

    function automatic logic [63:0] iso_invert(input logic [63:0] m);
        logic [63:0] r;
        logic [7:0] y;
        r = '0;
        for (int a = 0; a < 256; a++) begin
            y = map(m, 8'(a));
            for (int j = 0; j < 8; j++) if (y == 8'(1 << j)) r[8*j +: 8] = 8'(a);
        end
        return r;
    endfunction

    localparam logic [63:0] ISO = iso_basis();
    localparam logic [63:0] INV_ISO = iso_invert(ISO);

    function automatic logic [7:0] rotl(input logic [7:0] a, input int k);
        logic [15:0] t;
        t = {a, a} << k;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a, input logic inv);
        logic [7:0] t, x;
        t = inv ? rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05 : a;
        x = map(INV_ISO, gf256_inv(map(ISO, t)));
        return inv ? x : x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state;
    logic [CW-1:0] cnt;
    logic [127:0] st;
    logic mode;
    logic [7:0] lane_out [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_out[g] = sbox(st[8*(int'(cnt)*LANES+g) +: 8], mode);
    end

    assign in_ready = state == IDLE || (state == DONE && out_ready);
    assign out_valid = state == DONE;
    assign busy = state != IDLE;
    assign out_data = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            st <= '0;
            mode <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (in_valid && in_ready) begin
                        st <= in_data;
                        mode <= in_inv & INV_EN;
                        cnt <= '0;
                        state <= RUN;
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    for (int i = 0; i < LANES; i++) st[8*(int'(cnt)*LANES+i) +: 8] <= lane_out[i];
                    if (cnt == CW'(N - 1)) state <= DONE;
                    else cnt <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_subbytes_engine.sv
// tb_subbytes_engine: scoreboard bench for subbytes_engine with LANES 4/1/16 and an INV_EN=0 build.
// Expected blocks come from a brute-force GF(2^8) reference S-box built at time zero.
module tb_subbytes_engine;
    localparam int NDUT = 4;

    logic clk = 1'b0;
    logic rst;
    logic iv [NDUT];
    logic ii [NDUT];
    logic ordy [NDUT];
    logic ir [NDUT];
    logic ov [NDUT];
    logic bz [NDUT];
    logic [127:0] id [NDUT];
    logic [127:0] od [NDUT];
    logic [127:0] exq [NDUT][$];
    logic [7:0] sb [256];
    logic [7:0] isb [256];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        subbytes_engine #(.LANES(k == 1 ? 1 : k == 2 ? 16 : 4), .INV_EN(k != 3)) dut (
            .clk(clk), .rst(rst), .in_valid(iv[k]), .in_ready(ir[k]), .in_data(id[k]),
            .in_inv(ii[k]), .out_valid(ov[k]), .out_ready(ordy[k]), .out_data(od[k]), .busy(bz[k])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] v, s;
        v = '0;
        for (int b = 1; b < 256; b++) if (gmul(a, 8'(b)) == 8'h01) v = 8'(b);
        s = 8'h63;
        for (int i = 0; i < 8; i++)
            s[i] = s[i] ^ v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8];
        return s;
    endfunction

    function automatic logic [127:0] blk(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[8*j +: 8] = inv ? isb[d[8*j +: 8]] : sb[d[8*j +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] ramp(input int b);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[8*j +: 8] = 8'(16*b + j);
        return r;
    endfunction

    function automatic int nof(input int k);
        return k == 1 ? 16 : k == 2 ? 1 : 4;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++)
            if (ov[k] && ordy[k]) begin
                if (exq[k].size() == 0) check($sformatf("extra_out%0d", k), 128'(exq[k].size()), 1);
                else check($sformatf("out%0d", k), od[k], exq[k].pop_front());
            end
    end

    task automatic send(input int k, input logic [127:0] d, input logic inv);
        bit acc = 1'b0;
        iv[k] = 1'b1;
        id[k] = d;
        ii[k] = inv;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = ir[k];
            @(posedge clk);
            #1;
        end
        iv[k] = 1'b0;
        check($sformatf("accept%0d", k), 128'(acc), 1);
        if (acc) exq[k].push_back(blk(d, inv && k != 3));
    endtask

    task automatic latency(input int k, input logic [127:0] d, input logic inv);
        int n = 0;
        send(k, d, inv);
        while (!ov[k] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("latency%0d", k), 128'(n), 128'(nof(k)));
    endtask

    task automatic drain();
        for (int t = 0; t < 3000; t++) begin
            if (exq[0].size() + exq[1].size() + exq[2].size() + exq[3].size() == 0) break;
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < NDUT; k++) check($sformatf("drain%0d", k), 128'(exq[k].size()), 0);
    endtask

    initial begin
        int n, last;
        bit acc;
        logic [127:0] d;
        for (int k = 0; k < NDUT; k++) begin
            iv[k] = 1'b0;
            ii[k] = 1'b0;
            id[k] = '0;
            ordy[k] = 1'b1;
        end
        for (int a = 0; a < 256; a++) sb[a] = ref_sbox(8'(a));
        for (int a = 0; a < 256; a++) isb[sb[a]] = 8'(a);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(ov[0]), 0);
        check("rst_out_data", od[0], 0);
        check("rst_busy", 128'(bz[0]), 0);
        check("rst_in_ready", 128'(ir[0]), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        ordy[0] = 1'b0;
        latency(0, '0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("hold_data", od[0], {16{8'h63}});
            check("hold_valid", 128'(ov[0] & bz[0]), 1);
            @(posedge clk);
            #1;
        end
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", 128'(bz[0]), 0);
        check("idle_valid", 128'(ov[0]), 0);

        for (int k = 0; k < 3; k++) begin
            latency(k, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0);
            check($sformatf("vec_fwd%0d", k), od[k], 128'h76abd7fe2b670130c56f6bf27b777c63);
        end
        latency(0, 128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1);
        check("vec_inv", od[0], 128'h0f0e0d0c0b0a09080706050403020100);
        latency(3, 128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1);
        check("vec_inv_disabled", od[3], blk(128'h76abd7fe2b670130c56f6bf27b777c63, 1'b0));
        drain();

        for (int k = 0; k < 4; k++)
            for (int m = 0; m < 2; m++)
                for (int b = 0; b < 16; b++) send(k, ramp(b), m[0]);
        drain();

        n = 0;
        last = 0;
        iv[0] = 1'b1;
        ii[0] = 1'b0;
        id[0] = rnd128();
        for (int g = 0; g < 400 && n < 6; g++) begin
            @(negedge clk);
            acc = ir[0];
            @(posedge clk);
            #1;
            if (acc) begin
                exq[0].push_back(blk(id[0], 1'b0));
                if (n > 0) check("b2b_period", 128'(cyc - last), 5);
                last = cyc;
                n++;
                id[0] = rnd128();
            end
        end
        iv[0] = 1'b0;
        check("b2b_count", 128'(n), 6);
        drain();

        send(0, rnd128(), 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_valid", 128'(ov[0]), 0);
        check("abort_busy", 128'(bz[0]), 0);
        check("abort_data", od[0], 0);
        check("abort_ready", 128'(ir[0]), 1);
        exq[0].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_out", 128'(ov[0]), 0);
        d = rnd128();
        latency(0, d, 1'b1);
        check("after_abort", od[0], blk(d, 1'b1));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
